keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk_pre cycles per scan tick.
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive stable ticks to accept a press or a release.
REQ-003 Port clk_pre  input  1  board clock; the only clock.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port col_n  input  4  keypad columns, active-low, asynchronous to clk_pre.
REQ-006 Port key_ack  input  1  consumer acknowledge for key_valid.
REQ-007 Port row_n  output  4  keypad row drive, one-hot active-low.
REQ-008 Port key_valid  output  1  accepted key pending.
REQ-009 Port key_code  output  4  code of the pending key.
REQ-010 Port key_overrun  output  1  sticky flag: a key was dropped.
REQ-011 Port entry_bcd  output  16  four-digit BCD entry, digit 3 in [15:12].
REQ-012 Port entry_valid  output  1  one-cycle pulse on ENTER.

Function
REQ-013 col_n SHALL pass through a two-flop synchronizer; all decisions use only the synchronized value.
REQ-014 Divider SHALL count 0..SCAN_DIV-1 and assert a tick in the cycle where count equals SCAN_DIV-1, then wrap to 0.
REQ-015 Row index r (2 bits) SHALL drive row_n = ~(4'b0001 << r).
REQ-016 The FSM SHALL have states SCAN, DEBOUNCE, PRESSED, RELEASE; it changes state only on ticks.
REQ-017 In SCAN, on a tick with exactly one synchronized column low: capture the pattern, set stable count to 1, go to DEBOUNCE, and hold r.
REQ-018 In SCAN, on a tick with no column low, or with more than one column low (ghost): r <= r+1 mod 4 and stay in SCAN.
REQ-019 In DEBOUNCE, on a tick with the pattern equal to the captured one: increment the count; on reaching DEBOUNCE_SCANS, go to PRESSED and accept the key.
REQ-020 In DEBOUNCE, on a tick with a differing pattern (including release): return to SCAN with r unchanged.
REQ-021 Accepted code SHALL be {r, c}, where c is the index of the low column.
REQ-022 On acceptance with key_valid=0: load key_code and set key_valid.
REQ-023 On acceptance with key_valid=1: drop the key, keep key_code, and set key_overrun.
REQ-024 key_valid SHALL clear in the cycle after key_ack is sampled high.
REQ-025 If an acceptance and key_ack occur in the same cycle, the acceptance wins: key_valid stays 1, the new code loads, and no overrun is raised.
REQ-026 In PRESSED, a tick with all columns high SHALL go to RELEASE with count 1.
REQ-027 In RELEASE, an all-high tick SHALL increment the count; reaching DEBOUNCE_SCANS returns to SCAN with r advanced by 1.
REQ-028 In RELEASE, any low column SHALL return to PRESSED, so no second acceptance occurs.
REQ-029 Entry update on every accepted key, including a dropped one: code 0-9 sets entry_bcd <= {entry_bcd[11:0], code}.
REQ-030 Entry update: code 4'hA clears entry_bcd to 0.
REQ-031 Entry update: code 4'hF pulses entry_valid for one cycle, with entry_bcd unchanged.
REQ-032 Entry update: codes 4'hB-4'hE leave the entry unchanged.
REQ-033 key_ack while key_valid=0 SHALL have no effect.

Reset
REQ-034 On a clk_pre edge with reset=1, the block SHALL reset: FSM=SCAN, r=0, row_n=4'b1110, divider=0, count=0, synchronizer=4'b1111.
REQ-035 On the same reset edge, outputs SHALL reset: key_valid=0, key_code=0, key_overrun=0, entry_bcd=0, entry_valid=0.
REQ-036 Reset mid-press SHALL abandon the press; a still-held key SHALL be re-debounced from SCAN after reset.

Structure
REQ-037 Package keypad_pkg SHALL hold the FSM state enum, KEY_CLEAR=4'hA, KEY_ENTER=4'hF, and the default SCAN_DIV and DEBOUNCE_SCANS.
REQ-038 A single sub-module, col_sync (4-bit two-flop synchronizer), SHALL be instantiated; the rest is flat.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-039 Idle with col_n=4'hF: row_n cycles 1110,1101,1011,0111 every 4 clocks; key_valid stays 0.
REQ-040 Hold col_n=4'b1011 on row 1: key_valid=1 and key_code=4'h6 after 3 stable ticks; ack clears it next cycle; no repeat while held.
REQ-041 Press bounce: 2 stable ticks then release: no key accepted; scan resumes on row 1.
REQ-042 Keys 1,2,3,4 then F: entry_bcd=16'h1234 and a one-cycle entry_valid; then A gives entry_bcd=0.
REQ-043 Two keys without ack: second dropped, key_overrun=1, key_code keeps the first; col_n=4'b1001 (ghost) is ignored.
REQ-044 Reset asserted in PRESSED: all outputs reach their reset values; the held key is accepted again after 3 ticks.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
package keypad_pkg;

    // Scanner control states
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    localparam int DEFAULT_SCAN_DIV       = 100000;
    localparam int DEFAULT_DEBOUNCE_SCANS = 4;

    // True when exactly one active-low column is asserted
    function automatic logic exactly_one_low(input logic [3:0] cols);
        return ($countones(~cols) == 1);
    endfunction

    // Index of the lowest-numbered low column (0 when none is low)
    function automatic logic [1:0] low_col_index(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column inputs.
// Resets to all-high so an idle keypad is seen immediately after reset.
module col_sync (
    input  logic       clk_pre,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_reg;
    logic [3:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            // Per-column metastability chain
            always_ff @(posedge clk_pre) begin
                if (reset) begin
                    meta_reg[gi] <= 1'b1;
                    sync_reg[gi] <= 1'b1;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row drive, debounce, key handshake and BCD entry.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = DEFAULT_SCAN_DIV,
    parameter int DEBOUNCE_SCANS = DEFAULT_DEBOUNCE_SCANS
) (
    input  logic        clk_pre,
    input  logic        reset,
    input  logic [3:0]  col_n,
    input  logic        key_ack,
    output logic [3:0]  row_n,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_overrun,
    output logic [15:0] entry_bcd,
    output logic        entry_valid
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

    logic [3:0]       col_s;
    logic [DIV_W-1:0] div_reg;
    logic             tick;

    scan_state_t      state_reg, state_next;
    logic [1:0]       row_reg, row_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       pat_reg, pat_next;

    logic             single_low;
    logic             all_high;
    logic             accept;
    logic [3:0]       accept_code;

    logic             key_valid_reg;
    logic [3:0]       key_code_reg;
    logic             key_overrun_reg;
    logic [15:0]      entry_reg;
    logic             entry_valid_reg;

    col_sync u_col_sync (
        .clk_pre (clk_pre),
        .reset   (reset),
        .d       (col_n),
        .q       (col_s)
    );

    assign tick        = (div_reg == DIV_LAST);
    assign single_low  = exactly_one_low(col_s);
    assign all_high    = &col_s;
    assign cnt_inc     = cnt_reg + CNT_W'(1);
    assign accept_code = {row_reg, low_col_index(col_s)};

    // Scan-tick divider: wraps after the tick cycle
    always_ff @(posedge clk_pre) begin
        if (reset || tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    // Scanner state, row index, stability count and captured pattern
    always_ff @(posedge clk_pre) begin
        if (reset) begin
            state_reg <= SCAN;
            row_reg   <= 2'd0;
            cnt_reg   <= '0;
            pat_reg   <= 4'hF;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            cnt_reg   <= cnt_next;
            pat_reg   <= pat_next;
        end
    end

    // Next-state logic; everything moves only on a scan tick
    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        cnt_next   = cnt_reg;
        pat_next   = pat_reg;
        accept     = 1'b0;
        if (tick) begin
            case (state_reg)
                SCAN: begin
                    if (single_low) begin
                        // Hold this row while the candidate is debounced
                        pat_next   = col_s;
                        cnt_next   = CNT_W'(1);
                        state_next = DEBOUNCE;
                    end else begin
                        // Nothing or a ghost pattern: keep scanning
                        row_next = row_reg + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_s == pat_reg) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= CNT_TARGET) begin
                            state_next = PRESSED;
                            accept     = 1'b1;
                        end
                    end else begin
                        // Bounce or early release: retry the same row
                        cnt_next   = '0;
                        state_next = SCAN;
                    end
                end
                PRESSED: begin
                    if (all_high) begin
                        cnt_next   = CNT_W'(1);
                        state_next = RELEASE;
                    end
                end
                RELEASE: begin
                    if (all_high) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= CNT_TARGET) begin
                            cnt_next   = '0;
                            row_next   = row_reg + 2'd1;
                            state_next = SCAN;
                        end
                    end else begin
                        // Key bounced back down: no second acceptance
                        state_next = PRESSED;
                    end
                end
                default: begin
                    state_next = SCAN;
                end
            endcase
        end
    end

    // Key handshake and BCD entry register updates
    always_ff @(posedge clk_pre) begin
        if (reset) begin
            key_valid_reg   <= 1'b0;
            key_code_reg    <= 4'h0;
            key_overrun_reg <= 1'b0;
            entry_reg       <= 16'h0000;
            entry_valid_reg <= 1'b0;
        end else begin
            entry_valid_reg <= accept && (accept_code == KEY_ENTER);
            if (accept) begin
                // A simultaneous ack frees the slot, so the new key loads
                if (!key_valid_reg || key_ack) begin
                    key_code_reg  <= accept_code;
                    key_valid_reg <= 1'b1;
                end else begin
                    key_overrun_reg <= 1'b1;
                end
                // Entry tracks every accepted key, even a dropped one
                if (accept_code <= 4'd9) begin
                    entry_reg <= {entry_reg[11:0], accept_code};
                end else if (accept_code == KEY_CLEAR) begin
                    entry_reg <= 16'h0000;
                end
            end else if (key_ack) begin
                key_valid_reg <= 1'b0;
            end
        end
    end

    assign row_n       = ~(4'b0001 << row_reg);
    assign key_valid   = key_valid_reg;
    assign key_code    = key_code_reg;
    assign key_overrun = key_overrun_reg;
    assign entry_bcd   = entry_reg;
    assign entry_valid = entry_valid_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with a tick-level behavioural model.
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DB = 3;

    logic        clk_pre = 1'b0;
    logic        reset   = 1'b1;
    logic [3:0]  col_n   = 4'hF;
    logic        key_ack = 1'b0;
    logic [3:0]  row_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_overrun;
    logic [15:0] entry_bcd;
    logic        entry_valid;

    int checks = 0;
    int errors = 0;

    keypad_scan #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk_pre     (clk_pre),
        .reset       (reset),
        .col_n       (col_n),
        .key_ack     (key_ack),
        .row_n       (row_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_overrun (key_overrun),
        .entry_bcd   (entry_bcd),
        .entry_valid (entry_valid)
    );

    always #5 clk_pre = ~clk_pre;

    // Behavioural model: key is "latched" once accepted; streak counts
    // consecutive identical single-key ticks, rel counts idle ticks.
    int          m_row;
    bit          m_latched;
    int          m_streak;
    int          m_rel;
    logic [3:0]  m_cand;
    bit          m_valid;
    logic [3:0]  m_code;
    bit          m_ovr;
    logic [15:0] m_bcd;
    bit          m_ev;

    typedef struct {
        logic [3:0]  code;
        bit          ack;
        bit          e_valid;
        logic [3:0]  e_code;
        bit          e_ovr;
        logic [15:0] e_bcd;
        bit          e_ev;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_latched = 0; m_streak = 0; m_rel = 0; m_cand = 4'hF;
        m_valid = 0; m_code = 4'h0; m_ovr = 0; m_bcd = 16'h0; m_ev = 0;
    endtask

    // One scan tick of the model; ack_mode 1 = ack early in the period,
    // 2 = ack in the same cycle as the tick
    task automatic model_step(input logic [3:0] pat, input int ack_mode);
        int lows, c;
        bit acc;
        logic [3:0] code;
        lows = 0; c = 0; acc = 0; code = 4'h0;
        m_ev = 0;
        if (ack_mode == 1) m_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (!pat[i]) begin lows++; c = i; end
        end
        if (m_latched) begin
            if (pat == 4'hF) begin
                m_rel++;
                if (m_rel == DB) begin m_latched = 0; m_rel = 0; m_row = (m_row + 1) % 4; end
            end else begin
                m_rel = 0;
            end
        end else if (m_streak == 0) begin
            if (lows == 1) begin m_cand = pat; m_streak = 1; end
            else m_row = (m_row + 1) % 4;
        end else begin
            if (pat == m_cand) begin
                m_streak++;
                if (m_streak == DB) begin
                    m_latched = 1; m_streak = 0; m_rel = 0; acc = 1;
                    code = 4'(m_row * 4 + c);
                end
            end else begin
                m_streak = 0;
            end
        end
        if (acc) begin
            if (!m_valid || ack_mode == 2) begin m_code = code; m_valid = 1; end
            else m_ovr = 1;
            if (code < 10) m_bcd = {m_bcd[11:0], code};
            else if (code == 4'hA) m_bcd = 16'h0;
            else if (code == 4'hF) m_ev = 1;
        end else if (ack_mode == 2) begin
            m_valid = 0;
        end
    endtask

    task automatic check_model();
        logic [3:0] er;
        er = ~(4'b0001 << m_row);
        chk("row_n", row_n, er);
        chk("key_valid", key_valid, m_valid);
        chk("key_code", key_code, m_code);
        chk("key_overrun", key_overrun, m_ovr);
        chk("entry_bcd", entry_bcd, m_bcd);
        chk("entry_valid", entry_valid, m_ev);
    endtask

    // One full scan period; the tick lands on the last of the four edges
    task automatic period(input logic [3:0] pat, input int ack_mode);
        col_n = pat;
        for (int i = 0; i < SD; i++) begin
            key_ack = (ack_mode == 1 && i == 0) || (ack_mode == 2 && i == SD - 1);
            @(posedge clk_pre);
            @(negedge clk_pre);
            if (i == 0) chk("entry_valid_gap", entry_valid, 1'b0);
        end
        key_ack = 1'b0;
        model_step(pat, ack_mode);
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk_pre);
        @(negedge clk_pre);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic chk_reset_values();
        chk("rst_row_n", row_n, 4'b1110);
        chk("rst_key_valid", key_valid, 1'b0);
        chk("rst_key_code", key_code, 4'h0);
        chk("rst_key_overrun", key_overrun, 1'b0);
        chk("rst_entry_bcd", entry_bcd, 16'h0);
        chk("rst_entry_valid", entry_valid, 1'b0);
    endtask

    // Idle until the scanner reaches the key's row, then hold it DB ticks
    task automatic hold_key(input logic [3:0] code, input int last_ack);
        logic [3:0] pat;
        int guard;
        pat = ~(4'b0001 << code[1:0]);
        guard = 0;
        while (m_row != int'(code[3:2]) && guard < 8) begin
            period(4'hF, 0);
            guard++;
        end
        for (int i = 0; i < DB; i++) period(pat, (i == DB - 1) ? last_ack : 0);
    endtask

    task automatic release_key(input bit ack);
        for (int i = 0; i < DB; i++) period(4'hF, (i == 0 && ack) ? 1 : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{4'h6, 1'b1, 1'b1, 4'h6, 1'b0, 16'h0006, 1'b0};
        tbl[1] = '{4'hA, 1'b1, 1'b1, 4'hA, 1'b0, 16'h0000, 1'b0};
        tbl[2] = '{4'h1, 1'b1, 1'b1, 4'h1, 1'b0, 16'h0001, 1'b0};
        tbl[3] = '{4'h2, 1'b1, 1'b1, 4'h2, 1'b0, 16'h0012, 1'b0};
        tbl[4] = '{4'h3, 1'b1, 1'b1, 4'h3, 1'b0, 16'h0123, 1'b0};
        tbl[5] = '{4'h4, 1'b1, 1'b1, 4'h4, 1'b0, 16'h1234, 1'b0};
        tbl[6] = '{4'hF, 1'b1, 1'b1, 4'hF, 1'b0, 16'h1234, 1'b1};
        tbl[7] = '{4'hA, 1'b1, 1'b1, 4'hA, 1'b0, 16'h0000, 1'b0};
        tbl[8] = '{4'h5, 1'b0, 1'b1, 4'h5, 1'b0, 16'h0005, 1'b0};
        tbl[9] = '{4'h9, 1'b0, 1'b1, 4'h5, 1'b1, 16'h0059, 1'b0};

        // Reset state
        do_reset();
        chk_reset_values();

        // Idle scan: row advances every SD clocks
        for (int k = 1; k <= 2 * SD; k++) begin
            logic [3:0] er;
            @(posedge clk_pre);
            @(negedge clk_pre);
            er = ~(4'b0001 << ((k / SD) % 4));
            chk("idle_row_n", row_n, er);
            chk("idle_key_valid", key_valid, 1'b0);
        end
        model_step(4'hF, 0);
        model_step(4'hF, 0);
        for (int i = 0; i < 4; i++) period(4'hF, 0);

        // Table-driven key sequence
        for (int t = 0; t < 10; t++) begin
            hold_key(tbl[t].code, 0);
            $display("key %h: valid=%0d code=%h overrun=%0d bcd=%h entry_valid=%0d",
                     tbl[t].code, key_valid, key_code, key_overrun, entry_bcd, entry_valid);
            chk("tbl_key_valid", key_valid, tbl[t].e_valid);
            chk("tbl_key_code", key_code, tbl[t].e_code);
            chk("tbl_key_overrun", key_overrun, tbl[t].e_ovr);
            chk("tbl_entry_bcd", entry_bcd, tbl[t].e_bcd);
            chk("tbl_entry_valid", entry_valid, tbl[t].e_ev);
            release_key(tbl[t].ack);
        end

        // Ghost pattern ignored; overrun stays sticky through ack
        for (int i = 0; i < 6; i++) period(4'b1001, 0);
        $display("ghost: valid=%0d code=%h", key_valid, key_code);
        chk("ghost_key_code", key_code, 4'h5);
        chk("ghost_key_valid", key_valid, 1'b1);
        period(4'hF, 1);
        chk("ack_key_valid", key_valid, 1'b0);
        chk("sticky_overrun", key_overrun, 1'b1);

        // Held key: ack clears, no repeat while held
        do_reset();
        hold_key(4'h6, 0);
        $display("hold key 6: valid=%0d code=%h", key_valid, key_code);
        chk("hold_key_valid", key_valid, 1'b1);
        chk("hold_key_code", key_code, 4'h6);
        period(4'b1011, 1);
        chk("hold_ack_clear", key_valid, 1'b0);
        for (int i = 0; i < 3; i++) period(4'b1011, 0);
        chk("hold_no_repeat", key_valid, 1'b0);
        release_key(0);
        chk("release_row_adv", row_n, 4'b1011);

        // Bounce: two stable ticks then release, scan resumes on row 1
        while (m_row != 1) period(4'hF, 0);
        period(4'b1011, 0);
        period(4'b1011, 0);
        period(4'hF, 0);
        $display("bounce: valid=%0d row_n=%b", key_valid, row_n);
        chk("bounce_row_n", row_n, 4'b1101);
        chk("bounce_key_valid", key_valid, 1'b0);

        // Acceptance and ack in the same cycle: acceptance wins
        do_reset();
        hold_key(4'h1, 0);
        release_key(0);
        hold_key(4'h3, 2);
        $display("same-cycle ack: valid=%0d code=%h overrun=%0d", key_valid, key_code, key_overrun);
        chk("same_key_valid", key_valid, 1'b1);
        chk("same_key_code", key_code, 4'h3);
        chk("same_key_overrun", key_overrun, 1'b0);
        chk("same_entry_bcd", entry_bcd, 16'h0013);
        release_key(1);

        // Reset while a key is pressed; it must be accepted again
        do_reset();
        hold_key(4'h2, 0);
        chk("pre_rst_key_valid", key_valid, 1'b1);
        period(4'b1011, 0);
        do_reset();
        $display("reset mid-press: valid=%0d row_n=%b", key_valid, row_n);
        chk_reset_values();
        for (int i = 0; i < DB; i++) period(4'b1011, 0);
        $display("re-accept: valid=%0d code=%h", key_valid, key_code);
        chk("reacc_key_valid", key_valid, 1'b1);
        chk("reacc_key_code", key_code, 4'h2);
        chk("reacc_entry_bcd", entry_bcd, 16'h0002);
        release_key(1);

        // Randomized bursts against the model
        do_reset();
        for (int b = 0; b < 80; b++) begin
            logic [3:0] pat;
            int sel, len, am, c0, c1;
            sel = $urandom_range(0, 9);
            c0 = $urandom_range(0, 3);
            c1 = (c0 + $urandom_range(1, 3)) % 4;
            if (sel < 4) pat = 4'hF;
            else if (sel < 8) pat = ~(4'b0001 << c0);
            else if (sel == 8) pat = ~((4'b0001 << c0) | (4'b0001 << c1));
            else pat = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 5);
            for (int p = 0; p < len; p++) begin
                am = $urandom_range(0, 9);
                period(pat, (am < 2) ? 1 : ((am == 2) ? 2 : 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
